// File: rtl/linear_interp_if.sv
// Sample stream bundle for linear_interp: input side with ready handshake,
// output side as a strobed sample.
interface linear_interp_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         input_strobe;
    logic                         input_ready;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         output_strobe;

    // Source/sink side (sample producer and DAC-rate consumer)
    modport master (
        output data_in,
        output input_strobe,
        input  input_ready,
        input  data_out,
        input  output_strobe
    );

    // Interpolator side
    modport slave (
        input  data_in,
        input  input_strobe,
        output input_ready,
        output data_out,
        output output_strobe
    );
endinterface

// File: rtl/linear_interp.sv
// First-order interpolating upsampler: each accepted sample yields 2^INTERP_SHIFT
// outputs stepping linearly from the previous sample, with one sample buffered.
module linear_interp #(
    parameter int DATA_WIDTH   = 16,
    parameter int INTERP_SHIFT = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    linear_interp_if.slave  bus
);
    localparam int DIFF_W = DATA_WIDTH + 1;
    localparam int ACC_W  = DATA_WIDTH + 1 + INTERP_SHIFT;
    localparam logic [INTERP_SHIFT-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        ST_UNPRIMED,
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_WIDTH-1:0] r_prev;
    logic                         r_pend_valid;
    logic signed [DATA_WIDTH-1:0] r_pend_data;
    logic [INTERP_SHIFT-1:0]      r_k;
    logic signed [DIFF_W-1:0]     r_diff;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [DATA_WIDTH-1:0] r_data_out;
    logic                         r_out_strobe;

    logic                         w_ready;
    logic                         w_accept;
    logic                         w_k_last;
    logic                         w_step;
    logic                         w_load;
    logic signed [DIFF_W-1:0]     w_diff_new;
    logic signed [ACC_W-1:0]      w_load_acc;
    logic signed [ACC_W-1:0]      w_acc_step;

    // Control decode and next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = enable && !r_pend_valid;
        w_accept    = bus.input_strobe && w_ready;
        w_k_last    = (r_k == K_LAST);
        w_step      = enable && (r_state == ST_RUN);
        w_load      = enable && r_pend_valid && ((r_state != ST_RUN) || w_k_last);

        case (r_state)
            ST_UNPRIMED: if (w_accept) w_state_nxt = ST_IDLE;
            ST_IDLE:     if (w_load)   w_state_nxt = ST_RUN;
            ST_RUN:      if (w_step && w_k_last && !w_load) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_UNPRIMED;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_UNPRIMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Segment arithmetic: acc carries prev scaled by N and advances by the raw
    // difference each step, so acc >>> INTERP_SHIFT walks prev -> new in diff/N steps.
    always_comb begin
        w_diff_new = {r_pend_data[DATA_WIDTH-1], r_pend_data}
                   - {r_prev[DATA_WIDTH-1], r_prev};
        w_load_acc = {{(INTERP_SHIFT + 1){r_prev[DATA_WIDTH-1]}}, r_prev} << INTERP_SHIFT;
        w_acc_step = r_acc + {{INTERP_SHIFT{r_diff[DIFF_W-1]}}, r_diff};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_k          <= '0;
            r_diff       <= '0;
            r_acc        <= '0;
            r_data_out   <= '0;
            r_out_strobe <= 1'b0;
        end else if (enable) begin
            r_out_strobe <= w_step;

            // The slice is acc >>> INTERP_SHIFT truncated to DATA_WIDTH; the
            // result stays between the endpoints, so dropping the top bit is exact.
            if (w_step) begin
                r_data_out <= r_acc[INTERP_SHIFT + DATA_WIDTH - 1:INTERP_SHIFT];
                r_acc      <= w_acc_step;
                r_k        <= r_k + 1'b1;
            end

            // A load on the last step of a segment overrides the step update
            if (w_load) begin
                r_diff <= w_diff_new;
                r_acc  <= w_load_acc;
                r_prev <= r_pend_data;
                r_k    <= '0;
            end

            if (w_accept) begin
                if (r_state == ST_UNPRIMED) begin
                    r_prev <= bus.data_in;
                end else begin
                    r_pend_data <= bus.data_in;
                end
            end

            if (w_accept && (r_state != ST_UNPRIMED)) begin
                r_pend_valid <= 1'b1;
            end else if (w_load) begin
                r_pend_valid <= 1'b0;
            end
        end else begin
            r_out_strobe <= 1'b0;
        end
    end

    assign bus.input_ready   = w_ready;
    assign bus.data_out      = r_data_out;
    assign bus.output_strobe = r_out_strobe;
endmodule
